// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the output-stationary systolic multiply array: clears the PEs,
// streams K operand slices through the skewed array, then writes N result rows.
module matmul_seq_ctrl #(
    parameter int MAX_DIM = 4,
    parameter int DIM_W   = (MAX_DIM > 2) ? $clog2(MAX_DIM) : 1,
    parameter int CNT_W   = $clog2(3 * MAX_DIM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [DIM_W-1:0] k_dim_i,
    input  logic [DIM_W-1:0] m_dim_i,
    output logic             pe_clr_o,
    output logic             operand_vld_o,
    output logic [DIM_W-1:0] operand_idx_o,
    output logic             shift_en_o,
    output logic             res_wr_en_o,
    output logic [DIM_W-1:0] res_row_o,
    input  logic             res_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] feed_last;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;

    logic             pe_clr_q, pe_clr_d;
    logic             operand_vld_q, operand_vld_d;
    logic [DIM_W-1:0] operand_idx_q, operand_idx_d;
    logic             shift_en_q, shift_en_d;
    logic             res_wr_en_q, res_wr_en_d;
    logic [DIM_W-1:0] res_row_q, res_row_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Stored dims are minus-one values, so K+N+M-2 == k+n+m+1.
    assign feed_last = CNT_W'(k_q) + CNT_W'(n_q) + CNT_W'(m_q) + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        n_d     = n_q;
        k_d     = k_q;
        m_d     = m_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    n_d     = n_dim_i;
                    k_d     = k_dim_i;
                    m_d     = m_dim_i;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (cnt_q == feed_last) begin
                    row_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (res_ready_i) begin
                    if (row_q == n_q) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + DIM_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    always_comb begin
        pe_clr_d      = 1'b0;
        operand_vld_d = 1'b0;
        operand_idx_d = '0;
        shift_en_d    = 1'b0;
        res_wr_en_d   = 1'b0;
        res_row_d     = '0;
        busy_d        = 1'b0;
        done_d        = 1'b0;

        case (state_d)
            ST_CLEAR: begin
                pe_clr_d = 1'b1;
                busy_d   = 1'b1;
            end
            ST_FEED: begin
                busy_d     = 1'b1;
                shift_en_d = (cnt_d != '0);
                if (cnt_d <= CNT_W'(k_d)) begin
                    operand_vld_d = 1'b1;
                    operand_idx_d = cnt_d[DIM_W-1:0];
                end
            end
            ST_WRITE: begin
                busy_d      = 1'b1;
                res_wr_en_d = 1'b1;
                res_row_d   = row_d;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            row_q         <= '0;
            n_q           <= '0;
            k_q           <= '0;
            m_q           <= '0;
            pe_clr_q      <= 1'b0;
            operand_vld_q <= 1'b0;
            operand_idx_q <= '0;
            shift_en_q    <= 1'b0;
            res_wr_en_q   <= 1'b0;
            res_row_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            n_q           <= n_d;
            k_q           <= k_d;
            m_q           <= m_d;
            pe_clr_q      <= pe_clr_d;
            operand_vld_q <= operand_vld_d;
            operand_idx_q <= operand_idx_d;
            shift_en_q    <= shift_en_d;
            res_wr_en_q   <= res_wr_en_d;
            res_row_q     <= res_row_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pe_clr_o      = pe_clr_q;
    assign operand_vld_o = operand_vld_q;
    assign operand_idx_o = operand_idx_q;
    assign shift_en_o    = shift_en_q;
    assign res_wr_en_o   = res_wr_en_q;
    assign res_row_o     = res_row_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomized bench for matmul_seq_ctrl against a phase-timeline reference model.
module tb_matmul_seq_ctrl;

    localparam int DIM_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [DIM_W-1:0] n_dim_i, k_dim_i, m_dim_i;
    logic             pe_clr_o, operand_vld_o, shift_en_o, res_wr_en_o;
    logic [DIM_W-1:0] operand_idx_o, res_row_o;
    logic             res_ready_i;
    logic             busy_o, done_o;

    always #5 clk_i = ~clk_i;

    matmul_seq_ctrl #(.MAX_DIM(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .n_dim_i       (n_dim_i),
        .k_dim_i       (k_dim_i),
        .m_dim_i       (m_dim_i),
        .pe_clr_o      (pe_clr_o),
        .operand_vld_o (operand_vld_o),
        .operand_idx_o (operand_idx_o),
        .shift_en_o    (shift_en_o),
        .res_wr_en_o   (res_wr_en_o),
        .res_row_o     (res_row_o),
        .res_ready_i   (res_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ph is cycles elapsed since the accepted start
    // (0 = idle); the write phase parks at ph == K+N+M+1 until N rows land.
    int ph = 0, rows = 0, dn = 0;
    int mk = 1, mn = 1, mm = 1;
    int stall = 0;
    bit rand_ready = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit in_write();
        return (ph != 0) && (ph == mk + mn + mm + 1);
    endfunction

    task automatic check_outputs();
        int  knm, c;
        bit  feed, vld;
        knm  = mk + mn + mm;
        feed = (ph >= 2) && (ph <= knm);
        c    = ph - 2;
        vld  = feed && (c < mk);
        chk("pe_clr",      int'(pe_clr_o),      int'(ph == 1));
        chk("operand_vld", int'(operand_vld_o), int'(vld));
        chk("operand_idx", int'(operand_idx_o), vld ? c : 0);
        chk("shift_en",    int'(shift_en_o),    int'(feed && c >= 1));
        chk("res_wr_en",   int'(res_wr_en_o),   int'(in_write()));
        chk("res_row",     int'(res_row_o),     in_write() ? rows : 0);
        chk("busy",        int'(busy_o),        int'(ph != 0));
        chk("done",        int'(done_o),        dn);
    endtask

    task automatic step(input bit st, input bit rs);
        start_i = st;
        rst_i   = rs;
        if (in_write() && stall > 0) begin
            res_ready_i = 1'b0;
            stall--;
        end else if (rand_ready) begin
            res_ready_i = ($urandom_range(0, 3) != 0);
        end else begin
            res_ready_i = 1'b1;
        end

        if (rs) begin
            ph = 0; dn = 0; rows = 0;
        end else if (dn != 0) begin
            dn = 0;
        end else if (ph == 0) begin
            if (st) begin
                mn = int'(n_dim_i) + 1;
                mk = int'(k_dim_i) + 1;
                mm = int'(m_dim_i) + 1;
                ph = 1;
                rows = 0;
            end
        end else if (in_write()) begin
            if (res_ready_i) begin
                rows++;
                if (rows == mn) begin
                    ph = 0;
                    dn = 1;
                end
            end
        end else begin
            ph++;
        end

        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic set_dims(input int n, input int k, input int m);
        n_dim_i = DIM_W'(n);
        k_dim_i = DIM_W'(k);
        m_dim_i = DIM_W'(m);
    endtask

    task automatic run_to_idle(input int budget);
        int n = 0;
        while ((ph != 0 || dn != 0) && n < budget) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (ph != 0 || dn != 0) chk("idle_timeout", 1, 0);
        step(1'b0, 1'b0);
    endtask

    task automatic latency_run(input string tag, input int n, input int k, input int m);
        int cyc = 1;
        set_dims(n, k, m);
        step(1'b1, 1'b0);
        while (!done_o && cyc < 80) begin
            step(1'b0, 1'b0);
            cyc++;
        end
        chk(tag, cyc, (k + 1) + 2 * (n + 1) + (m + 1) + 1);
        run_to_idle(80);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; res_ready_i = 1'b1;
        set_dims(0, 0, 0);
        repeat (3) step(1'b0, 1'b1);

        // 1: all dims max, done 17 cycles after start
        latency_run("latency_444", 3, 3, 3);
        // 2: minimal 1x1x1, done 5 cycles after start
        latency_run("latency_111", 0, 0, 0);

        // 3: N=2,K=3,M=4 with a 3-cycle stall on the first row
        set_dims(1, 2, 3);
        stall = 3;
        step(1'b1, 1'b0);
        run_to_idle(80);

        // 4: second start during FEED with different dims is ignored
        set_dims(3, 3, 3);
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        set_dims(0, 1, 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        run_to_idle(80);

        // 5: reset while writing row 1 of 4, then a clean rerun
        set_dims(3, 2, 1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 60 && !(in_write() && rows == 1); i++) step(1'b0, 1'b0);
        chk("reached_row1", int'(in_write() && rows == 1), 1);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        run_to_idle(80);

        // 6: start held high -> back-to-back operations
        set_dims(1, 0, 2);
        repeat (40) step(1'b1, 1'b0);
        run_to_idle(80);

        // Random operations with random backpressure, stray starts and resets
        rand_ready = 1;
        for (int op = 0; op < 40; op++) begin
            set_dims($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            step(1'b1, 1'b0);
            for (int c = 0; c < 80 && (ph != 0 || dn != 0); c++) begin
                if ($urandom_range(0, 9) == 0)
                    set_dims($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                step($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
            end
            if (ph != 0 || dn != 0) chk("rand_timeout", 1, 0);
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
